uart_rx_fifo: RTL

Parametrised UART receiver with an oversampling bit timer, glitch-rejecting start detection and a first-word-fall-through receive FIFO. It sits between the board `UART_RX` pin and the CPU pipeline's peripheral bus, and replaces the fixed 8N1 receive path. Software reads bytes through a valid/ready handshake. Framing and overrun events are flagged as single-cycle pulses.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/uart_rx_fifo.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Purpose : Shared UART types and default parameter constants.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 16;
  localparam int UART_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    S_WAIT_HIGH = 3'd0,
    S_IDLE      = 3'd1,
    S_START     = 3'd2,
    S_DATA      = 3'd3,
    S_PARITY    = 3'd4,
    S_STOP      = 3'd5
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module  : sync_fifo
// Purpose : First-word-fall-through synchronous FIFO, power-of-two depth.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_push,
  input  logic [WIDTH-1:0]               i_data,
  input  logic                           i_pop,
  output logic [WIDTH-1:0]               o_data,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [$clog2(DEPTH+1)-1:0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_do_pop  = i_pop && !o_empty;
  // A pop frees the slot in the same edge, so a full FIFO can still accept.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module  : uart_rx_fifo
// Purpose : Oversampling UART receiver feeding an FWFT receive FIFO.
//           Optional even parity via macro UART_RX_PARITY_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                UART_RX,
  output logic [DATA_BITS-1:0]                rx_data,
  output logic                                rx_valid,
  input  logic                                rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count,
  output logic                                frame_err,
  output logic                                overrun,
  output logic                                parity_err
);

  localparam int                CNT_W      = $clog2(CLKS_PER_BIT);
  localparam int                BIT_W      = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]  c_HALF     = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0]  c_FULL     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  c_LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 w_rxs;
  rx_state_t            r_state;
  rx_state_t            w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [BIT_W-1:0]     r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 w_tick_half;
  logic                 w_tick_full;
  logic                 w_stop_sample;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_par_bad;
  logic                 w_full;
  logic                 w_empty;
  logic                 r_frame_err;
  logic                 r_overrun;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= UART_RX;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs       = r_sync2;
  assign w_tick_half = (r_cnt == c_HALF);
  assign w_tick_full = (r_cnt == c_FULL);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_WAIT_HIGH;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT_HIGH: if (w_rxs)  w_state_nxt = S_IDLE;
      S_IDLE:      if (!w_rxs) w_state_nxt = S_START;
      S_START:     if (w_tick_half) w_state_nxt = w_rxs ? S_IDLE : S_DATA;
      S_DATA: begin
        if (w_tick_full && (r_bit == c_LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
          w_state_nxt = S_PARITY;
`else
          w_state_nxt = S_STOP;
`endif
        end
      end
      S_PARITY:    if (w_tick_full) w_state_nxt = S_STOP;
      // A low stop bit may be a break; wait for the line to recover.
      S_STOP:      if (w_tick_full) w_state_nxt = w_rxs ? S_IDLE : S_WAIT_HIGH;
      default:     w_state_nxt = S_WAIT_HIGH;
    endcase
  end

  always_comb begin
    w_stop_sample = (r_state == S_STOP) && w_tick_full;
    w_push        = w_stop_sample && w_rxs && !w_par_bad;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        S_START:                  r_cnt <= w_tick_half ? '0 : r_cnt + CNT_W'(1);
        S_DATA, S_PARITY, S_STOP: r_cnt <= w_tick_full ? '0 : r_cnt + CNT_W'(1);
        default:                  r_cnt <= '0;
      endcase
      if (r_state == S_START) begin
        r_bit <= '0;
      end else if ((r_state == S_DATA) && w_tick_full) begin
        r_bit   <= r_bit + BIT_W'(1);
        r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  logic r_parity_err;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (r_state == S_START) begin
        r_par_bad <= 1'b0;
      end else if ((r_state == S_PARITY) && w_tick_full) begin
        r_par_bad <= w_rxs ^ (^r_shift);
      end
      // Reported alongside the stop-bit result so all flags share one timing.
      r_parity_err <= w_stop_sample && r_par_bad;
    end
  end

  assign w_par_bad  = r_par_bad;
  assign parity_err = r_parity_err;
`else
  assign w_par_bad  = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign w_pop = rx_valid && rx_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_stop_sample && !w_rxs;
      r_overrun   <= w_push && w_full && !w_pop;
    end
  end

  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign rx_valid  = !w_empty;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (r_shift),
    .i_pop   (w_pop),
    .o_data  (rx_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

endmodule

`default_nettype wire
